// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: carries conditional branches from ID into EX, resolves them,
// reports the outcome, and redirects/flushes on a mispredict. Optional counters: BRU_STATS_EN.
module branch_resolve_unit #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_pc,
  input  logic            id_prediction,
  input  logic [XLEN-1:0] ex_rs1_val,
  input  logic [XLEN-1:0] ex_rs2_val,
  output logic            outcome,
  output logic            outcome_valid,
  output logic            mispredict,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // ID->EX pipeline register
  logic            ex_valid_q, ex_valid_d;
  logic [2:0]      ex_funct3_q, ex_funct3_d;
  logic [XLEN-1:0] ex_pc_q, ex_pc_d;
  logic [XLEN-1:0] ex_imm_q, ex_imm_d;
  logic            ex_pred_q, ex_pred_d;

  // Registered outputs
  logic            outcome_q, outcome_d;
  logic            outcome_valid_q, outcome_valid_d;
  logic            mispredict_q, mispredict_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            taken_s;
  logic            resolve_s;
  logic            ex_mispredict_now_s;
  logic            flush_s;
  logic [XLEN-1:0] id_imm_s;
  logic            unused_instr_s;

  assign unused_instr_s = ^id_instr[24:15];
  assign flush_s        = (state_q == ST_FLUSH);
  assign id_imm_s       = {{(XLEN-13){id_instr[31]}}, id_instr[31], id_instr[7],
                           id_instr[30:25], id_instr[11:8], 1'b0};
  assign resolve_s           = ex_valid_q & ~stall;
  assign ex_mispredict_now_s = resolve_s & (taken_s != ex_pred_q);

  // Branch condition evaluation on the registered funct3
  always_comb begin
    taken_s = 1'b0;
    case (ex_funct3_q)
      3'b000:  taken_s = (ex_rs1_val == ex_rs2_val);
      3'b001:  taken_s = (ex_rs1_val != ex_rs2_val);
      3'b100:  taken_s = ($signed(ex_rs1_val) <  $signed(ex_rs2_val));
      3'b101:  taken_s = ($signed(ex_rs1_val) >= $signed(ex_rs2_val));
      3'b110:  taken_s = (ex_rs1_val <  ex_rs2_val);
      3'b111:  taken_s = (ex_rs1_val >= ex_rs2_val);
      default: taken_s = 1'b0;
    endcase
  end

  // ID->EX next state; flush and an in-flight mispredict both squash the capture
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_funct3_d = ex_funct3_q;
    ex_pc_d     = ex_pc_q;
    ex_imm_d    = ex_imm_q;
    ex_pred_d   = ex_pred_q;
    if (!stall) begin
      ex_valid_d  = id_valid & (id_instr[6:0] == OPC_BRANCH) & ~flush_s & ~ex_mispredict_now_s;
      ex_funct3_d = id_instr[14:12];
      ex_pc_d     = id_pc;
      ex_imm_d    = id_imm_s;
      ex_pred_d   = id_prediction;
    end else begin
      ex_valid_d  = ex_valid_q;
      ex_funct3_d = ex_funct3_q;
    end
  end

  // Result pulses and held outcome / redirect target
  always_comb begin
    outcome_valid_d = resolve_s;
    mispredict_d    = ex_mispredict_now_s;
    outcome_d       = outcome_q;
    redirect_pc_d   = redirect_pc_q;
    if (resolve_s) begin
      outcome_d = taken_s;
    end else begin
      outcome_d = outcome_q;
    end
    if (ex_mispredict_now_s) begin
      redirect_pc_d = taken_s ? (ex_pc_q + ex_imm_q)
                              : (ex_pc_q + {{(XLEN-3){1'b0}}, 3'b100});
    end else begin
      redirect_pc_d = redirect_pc_q;
    end
  end

  // Flush FSM next state; a mispredict always reloads the counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (ex_mispredict_now_s) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (ex_mispredict_now_s) begin
          cnt_d = CNT_LOAD;
        end else if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // All state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q      <= 1'b0;
      ex_funct3_q     <= 3'b000;
      ex_pc_q         <= {XLEN{1'b0}};
      ex_imm_q        <= {XLEN{1'b0}};
      ex_pred_q       <= 1'b0;
      outcome_q       <= 1'b0;
      outcome_valid_q <= 1'b0;
      mispredict_q    <= 1'b0;
      redirect_pc_q   <= {XLEN{1'b0}};
      state_q         <= ST_IDLE;
      cnt_q           <= {CNT_W{1'b0}};
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_funct3_q     <= ex_funct3_d;
      ex_pc_q         <= ex_pc_d;
      ex_imm_q        <= ex_imm_d;
      ex_pred_q       <= ex_pred_d;
      outcome_q       <= outcome_d;
      outcome_valid_q <= outcome_valid_d;
      mispredict_q    <= mispredict_d;
      redirect_pc_q   <= redirect_pc_d;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
    end
  end

  assign outcome        = outcome_q;
  assign outcome_valid  = outcome_valid_q;
  assign mispredict     = mispredict_q;
  assign redirect_valid = mispredict_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_s;

`ifdef BRU_STATS_EN
  logic [31:0] stat_br_q, stat_mp_q;

  // Saturating event counters, stepped on the edge that registers each pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_br_q <= 32'h0000_0000;
      stat_mp_q <= 32'h0000_0000;
    end else begin
      if (resolve_s && (stat_br_q != 32'hFFFF_FFFF)) begin
        stat_br_q <= stat_br_q + 32'd1;
      end
      if (ex_mispredict_now_s && (stat_mp_q != 32'hFFFF_FFFF)) begin
        stat_mp_q <= stat_mp_q + 32'd1;
      end
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule
